// File: rtl/captador_numerico_if.sv
// Committed-value handshake between captador_numerico and its consumer.
// master: drives VALOR/VALOR_VALIDO, samples PRONTO; slave: the reverse.
interface captador_numerico_if #(
    parameter int VALUE_W = 10
);
    logic [VALUE_W-1:0] VALOR;
    logic               VALOR_VALIDO;
    logic               PRONTO;

    modport master (
        output VALOR,
        output VALOR_VALIDO,
        input  PRONTO
    );

    modport slave (
        input  VALOR,
        input  VALOR_VALIDO,
        output PRONTO
    );
endinterface

// File: rtl/captador_numerico.sv
// Switch/key front-end: synchronize, debounce, edge-detect, accumulate
// decimal digits and hand the committed value downstream (valid/ready).
//
// Ports:
//   ADC_CLK_10   system clock
//   RESET        synchronous, active-high reset
//   SW[0:9]      raw switches; a debounced rise on SW[n] enters digit n
//   KEY_PROXIMO  raw "next" key: commits the accumulated value
//   KEY_CLEAR    raw "clear" key: drops entry, error and pending value
//   saida        VALOR / VALOR_VALIDO out, PRONTO in
//   PARCIAL      live accumulator (for the HEX display)
//   NUM_DIGITOS  digits currently accumulated
//   ERRO         sticky entry error
module captador_numerico #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 3,
    parameter int VALUE_W         = 10
) (
    input  logic               ADC_CLK_10,
    input  logic               RESET,
    input  logic [0:9]         SW,
    input  logic               KEY_PROXIMO,
    input  logic               KEY_CLEAR,
    captador_numerico_if.master saida,
    output logic [VALUE_W-1:0] PARCIAL,
    output logic [1:0]         NUM_DIGITOS,
    output logic               ERRO
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [1:0] NUM_MAX = 2'(MAX_DIGITS);

    localparam int B_PROX = 10;
    localparam int B_CLR  = 11;

    typedef enum logic {
        COLETA,
        PENDENTE
    } estado_t;

    // bits 0..9 = SW digit n, bit 10 = next key, bit 11 = clear key
    logic [11:0] bruto;
    logic [11:0] sinc_a;
    logic [11:0] sinc_b;
    logic [11:0] sinc_ant;
    logic [11:0] estavel;
    logic [11:0] estavel_n;
    logic [11:0] borda;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    estado_t            estado;
    estado_t            estado_n;
    logic [VALUE_W-1:0] valor_q;
    logic [VALUE_W-1:0] valor_n;
    logic [VALUE_W-1:0] parcial_q;
    logic [VALUE_W-1:0] parcial_n;
    logic [VALUE_W-1:0] vezes10;
    logic [1:0]         num_q;
    logic [1:0]         num_n;
    logic               erro_q;
    logic               erro_n;
    logic [3:0]         digito;

    always_comb begin
        bruto = '0;
        for (int i = 0; i < 10; i++) begin
            bruto[i] = SW[i];
        end
        bruto[B_PROX] = KEY_PROXIMO;
        bruto[B_CLR]  = KEY_CLEAR;
    end

    // cnt counts how many consecutive cycles the synchronized vector has
    // held its current value (1 on the cycle it changes), saturating.
    // The vector is adopted on the cycle that count reaches the target,
    // and the edge register sees old vs. new debounced level directly.
    always_comb begin
        if (sinc_b != sinc_ant) begin
            cnt_n = CNT_W'(1);
        end else if (cnt == CNT_MAX) begin
            cnt_n = cnt;
        end else begin
            cnt_n = cnt + CNT_W'(1);
        end
        estavel_n = (cnt_n == CNT_MAX) ? sinc_b : estavel;
    end

    always_ff @(posedge ADC_CLK_10) begin
        if (RESET) begin
            sinc_a   <= '0;
            sinc_b   <= '0;
            sinc_ant <= '0;
            estavel  <= '0;
            cnt      <= '0;
            borda    <= '0;
        end else begin
            sinc_a   <= bruto;
            sinc_b   <= sinc_a;
            sinc_ant <= sinc_b;
            estavel  <= estavel_n;
            cnt      <= cnt_n;
            borda    <= estavel_n & ~estavel;
        end
    end

    assign vezes10 = (parcial_q << 3) + (parcial_q << 1);

    always_comb begin
        estado_n  = estado;
        valor_n   = valor_q;
        parcial_n = parcial_q;
        num_n     = num_q;
        erro_n    = erro_q;
        digito    = '0;

        for (int i = 0; i < 10; i++) begin
            if (borda[i]) begin
                digito = 4'(i);
            end
        end

        // handshake completes independently of the entry keys
        if (estado == PENDENTE && saida.PRONTO) begin
            estado_n = COLETA;
        end

        if (borda[B_CLR]) begin
            parcial_n = '0;
            num_n     = '0;
            erro_n    = 1'b0;
            estado_n  = COLETA;
        end else if (borda[B_PROX]) begin
            // a coincident digit edge is dropped silently
            if (estado == PENDENTE) begin
                erro_n = 1'b1;
            end else if (num_q != 2'd0) begin
                valor_n   = parcial_q;
                parcial_n = '0;
                num_n     = '0;
                erro_n    = 1'b0;
                estado_n  = PENDENTE;
            end
        end else if (borda[9:0] != 10'd0) begin
            if (!$onehot(borda[9:0])) begin
                erro_n = 1'b1;
            end else if (num_q >= NUM_MAX) begin
                erro_n = 1'b1;
            end else begin
                parcial_n = vezes10 + VALUE_W'(digito);
                num_n     = num_q + 2'd1;
            end
        end
    end

    always_ff @(posedge ADC_CLK_10) begin
        if (RESET) begin
            estado    <= COLETA;
            valor_q   <= '0;
            parcial_q <= '0;
            num_q     <= '0;
            erro_q    <= 1'b0;
        end else begin
            estado    <= estado_n;
            valor_q   <= valor_n;
            parcial_q <= parcial_n;
            num_q     <= num_n;
            erro_q    <= erro_n;
        end
    end

    assign saida.VALOR        = valor_q;
    assign saida.VALOR_VALIDO = (estado == PENDENTE);
    assign PARCIAL            = parcial_q;
    assign NUM_DIGITOS        = num_q;
    assign ERRO               = erro_q;

endmodule

// File: doc/captador_numerico.md
Name: captador_numerico

Overview:
- Input front-end for the diabetes detector on the DE10-Lite board.
- Synchronizes and debounces the raw switch and key inputs, and converts one-hot SW pulses into decimal digits.
- Accumulates up to MAX_DIGITS digits into a binary value. The "próximo" key delivers that value downstream through a valid/ready handshake.
- Sits directly upstream of detector_de_diabetes and replaces raw SW/KEY handling there.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles before a debounced level changes; minimum 1.
MAX_DIGITS, 3, maximum digits per value.
VALUE_W, 10, width of the accumulated value; must hold 10^MAX_DIGITS - 1.

Ports:
ADC_CLK_10  in  1  system clock
RESET  in  1  synchronous, active-high reset
SW  in  [0:9]  raw switches, active-high; SW[n] pulse enters digit n
KEY_PROXIMO  in  1  raw "next" key, active-high
KEY_CLEAR  in  1  raw "clear" key, active-high
PRONTO  in  1  downstream ready
VALOR  out  VALUE_W  committed value, stable while VALOR_VALIDO is high
VALOR_VALIDO  out  1  committed value is available
PARCIAL  out  VALUE_W  live accumulator, for HEX display
NUM_DIGITOS  out  2  digits currently accumulated
ERRO  out  1  sticky entry error

Behaviour:
- Reset: everything clears when RESET is high at a clock edge.
  - Outputs: VALOR=0, VALOR_VALIDO=0, PARCIAL=0, NUM_DIGITOS=0, ERRO=0.
  - Internals: synchronizers, debounced vector, debounce counter and edge registers = 0; state = COLETA.
  - Reset mid-operation discards any partial or pending value.
- Input conditioning:
  - All 12 raw inputs pass through 2-flop synchronizers.
  - One shared debouncer covers the 12-bit synchronized vector. The counter resets whenever the vector differs from the previous cycle. When the vector has been unchanged for DEBOUNCE_CYCLES cycles, it is copied to the debounced vector.
  - A rising edge is debounced(t)=1 and debounced(t-1)=0. The edge pulse is registered.
  - Pulses held for fewer than DEBOUNCE_CYCLES synchronized cycles never register.
  - Latency from a raw rise to the resulting PARCIAL/VALOR_VALIDO update is exactly DEBOUNCE_CYCLES+3 clocks, for an input held stable for at least that long.
- State COLETA (entry):
  - Exactly one SW rising edge n, with NUM_DIGITOS < MAX_DIGITS: PARCIAL <= PARCIAL*10 + n and NUM_DIGITOS++.
  - SW edge with NUM_DIGITOS == MAX_DIGITS: digit ignored, ERRO <= 1.
  - More than one SW rising edge in the same cycle: all ignored, ERRO <= 1.
  - KEY_PROXIMO edge with NUM_DIGITOS > 0: VALOR <= PARCIAL, VALOR_VALIDO <= 1, PARCIAL <= 0, NUM_DIGITOS <= 0, ERRO <= 0; go to PENDENTE.
  - KEY_PROXIMO edge with NUM_DIGITOS == 0: ignored, no pulse.
- State PENDENTE (handshake):
  - VALOR_VALIDO stays high and VALOR stays stable.
  - On a cycle where VALOR_VALIDO=1 and PRONTO=1, transfer occurs. Next cycle VALOR_VALIDO=0 and state returns to COLETA. With PRONTO held high, VALOR_VALIDO is high for exactly 1 cycle.
  - SW edges in PENDENTE accumulate normally into PARCIAL (type-ahead).
  - KEY_PROXIMO edges in PENDENTE are ignored and set ERRO.
- KEY_CLEAR edge (any state): PARCIAL=0, NUM_DIGITOS=0, ERRO=0, VALOR_VALIDO=0, state COLETA. A pending value is discarded; VALOR keeps its last value.
- Same-cycle priority: RESET > KEY_CLEAR > KEY_PROXIMO > SW.
  - With a simultaneous SW edge, the digit is dropped and ERRO is not set.
- Arithmetic: accumulation is unsigned VALUE_W-bit. Overflow is impossible given the MAX_DIGITS guard.
- ERRO is sticky until a KEY_CLEAR edge, a successful commit, or RESET.

Test Plan:
- Enter digits 1,4,8, then press next, with PRONTO=1 → VALOR=148 and VALOR_VALIDO high for 1 cycle; PARCIAL=0, NUM_DIGITOS=0. Verify the DEBOUNCE_CYCLES+3 latency from the raw KEY_PROXIMO rise.
- Enter 1,2,3,4 → PARCIAL=123, ERRO=1. Then press next → VALOR=123, ERRO=0.
- Raise SW[3] and SW[5] in the same cycle → PARCIAL unchanged, ERRO=1. Then press clear → ERRO=0.
- Hold PRONTO=0 and commit 72 → VALOR_VALIDO stays high with VALOR=72.
  - Meanwhile enter 3,5 → PARCIAL=35.
  - A second next press is ignored and sets ERRO.
  - Raise PRONTO → exactly one transfer; VALOR_VALIDO falls the next cycle.
- SW[6] glitch of 2 cycles (with DEBOUNCE_CYCLES=4) → no change. The same pulse held for 5 cycles → PARCIAL=6.
- Press next with no digits → no pulse. Enter 5 then 0, and assert RESET before next → all outputs 0 and no VALOR_VALIDO.
